// File: rtl/ps2_pkg.sv
// Shared PS/2 receiver definitions: FSM state encoding and well-known device codes.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } ps2_state_t;

  localparam logic [7:0] PS2_BAT_OK     = 8'hAA;
  localparam logic [7:0] PS2_BAT_FAIL   = 8'hFC;
  localparam int         PS2_FRAME_BITS = 11;

endpackage

// File: rtl/ps2_line_filter.sv
// Two-flop synchroniser plus run-length glitch filter for one PS/2 pin.
// The filtered level idles high and fall pulses for one cycle on a filtered 1->0 change.
module ps2_line_filter #(
  parameter int FILTER_LEN = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic line_in,
  output logic level,
  output logic fall
);

  localparam int CW = $clog2(FILTER_LEN + 1);

  logic [1:0]    sync;
  logic [CW-1:0] run_cnt;
  logic          level_d;

  // The level only moves after FILTER_LEN consecutive samples that disagree with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync    <= 2'b11;
      run_cnt <= '0;
      level   <= 1'b1;
      level_d <= 1'b1;
    end else begin
      sync    <= {sync[0], line_in};
      level_d <= level;
      if (sync[1] == level) begin
        run_cnt <= '0;
      end else if (run_cnt == CW'(FILTER_LEN - 1)) begin
        level   <= sync[1];
        run_cnt <= '0;
      end else begin
        run_cnt <= run_cnt + CW'(1);
      end
    end
  end

  assign fall = level_d & ~level;

endmodule

// File: rtl/ps2_rx_frame.sv
// PS/2 device-to-host frame receiver with start/parity/stop checking and BAT detection.
// Optional inter-edge frame timeout is enabled by defining PS2_RX_TIMEOUT_EN.
module ps2_rx_frame
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 2000,
  parameter int TIMEOUT_WIDTH  = 11
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  input  logic       host_inhibit,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_err,
  output logic       reset_required,
  output logic       busy
);

  if (TIMEOUT_CYCLES >= (1 << TIMEOUT_WIDTH)) begin : g_bad_timeout_cfg
    $error("ps2_rx_frame: TIMEOUT_WIDTH too narrow for TIMEOUT_CYCLES");
  end

  ps2_state_t state;
  logic [7:0] shift_reg;
  logic [2:0] bit_cnt;
  logic       parity;
  logic       par_err;
  logic       clk_level_unused;
  logic       clk_fall;
  logic       data_level;
  logic       data_fall_unused;

`ifdef PS2_RX_TIMEOUT_EN
  logic [TIMEOUT_WIDTH-1:0] tmo_cnt;
`endif

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
    .clk     (clk),
    .rst_n   (rst_n),
    .line_in (ps2_clk_in),
    .level   (clk_level_unused),
    .fall    (clk_fall)
  );

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filter (
    .clk     (clk),
    .rst_n   (rst_n),
    .line_in (ps2_data_in),
    .level   (data_level),
    .fall    (data_fall_unused)
  );

  // Inhibit outranks any edge; otherwise each filtered clock fall advances the frame by one bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      shift_reg      <= '0;
      bit_cnt        <= '0;
      parity         <= 1'b0;
      par_err        <= 1'b0;
      rx_data        <= '0;
      rx_valid       <= 1'b0;
      rx_err         <= 1'b0;
      reset_required <= 1'b0;
`ifdef PS2_RX_TIMEOUT_EN
      tmo_cnt        <= '0;
`endif
    end else begin
      rx_valid       <= 1'b0;
      rx_err         <= 1'b0;
      reset_required <= 1'b0;
      if (host_inhibit) begin
        state   <= IDLE;
        bit_cnt <= '0;
        parity  <= 1'b0;
        par_err <= 1'b0;
`ifdef PS2_RX_TIMEOUT_EN
        tmo_cnt <= '0;
`endif
      end else if (clk_fall) begin
`ifdef PS2_RX_TIMEOUT_EN
        tmo_cnt <= '0;
`endif
        unique case (state)
          IDLE: begin
            if (!data_level) begin
              state   <= DATA;
              bit_cnt <= '0;
              parity  <= 1'b0;
              par_err <= 1'b0;
            end else begin
              rx_err <= 1'b1;
            end
          end
          DATA: begin
            shift_reg[bit_cnt] <= data_level;
            parity             <= parity ^ data_level;
            bit_cnt            <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= PARITY;
          end
          PARITY: begin
            par_err <= ~(parity ^ data_level);
            state   <= STOP;
          end
          STOP: begin
            if (data_level && !par_err) begin
              rx_data        <= shift_reg;
              rx_valid       <= 1'b1;
              reset_required <= (shift_reg == PS2_BAT_OK);
            end else begin
              rx_err <= 1'b1;
            end
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
`ifdef PS2_RX_TIMEOUT_EN
      end else if (state != IDLE) begin
        if (tmo_cnt == TIMEOUT_WIDTH'(TIMEOUT_CYCLES)) begin
          state   <= IDLE;
          rx_err  <= 1'b1;
          tmo_cnt <= '0;
        end else begin
          tmo_cnt <= tmo_cnt + TIMEOUT_WIDTH'(1);
        end
`endif
      end
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_ps2_rx_frame.sv
// Scoreboard bench for ps2_rx_frame: directed PS/2 frames, glitches, inhibit and (optionally) timeout.
module tb_ps2_rx_frame;

  typedef struct {
    logic       is_err;
    logic [7:0] data;
    logic       rst_req;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       ps2_clk_in;
  logic       ps2_data_in;
  logic       host_inhibit;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_err;
  logic       reset_required;
  logic       busy;

  exp_t       exp_q[$];
  int         n_tests = 0;
  int         n_fail  = 0;
  logic [7:0] last_good = 8'h00;

  ps2_rx_frame #(
    .FILTER_LEN     (4),
    .TIMEOUT_CYCLES (100),
    .TIMEOUT_WIDTH  (11)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .ps2_clk_in     (ps2_clk_in),
    .ps2_data_in    (ps2_data_in),
    .host_inhibit   (host_inhibit),
    .rx_data        (rx_data),
    .rx_valid       (rx_valid),
    .rx_err         (rx_err),
    .reset_required (reset_required),
    .busy           (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void check_output(input string name, input logic [31:0] actual,
                                       input logic [31:0] expected);
    n_tests++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endfunction

  function automatic logic [10:0] make_frame(input logic [7:0] data, input logic flip_par);
    return {1'b1, (~^data) ^ flip_par, data, 1'b0};
  endfunction

  function automatic void push_good(input logic [7:0] data);
    exp_t e;
    e.is_err  = 1'b0;
    e.data    = data;
    e.rst_req = (data == 8'hAA);
    exp_q.push_back(e);
    last_good = data;
  endfunction

  function automatic void push_err();
    exp_t e;
    e.is_err  = 1'b1;
    e.data    = last_good;
    e.rst_req = 1'b0;
    exp_q.push_back(e);
  endfunction

  // Each bit: data set while the clock is high for 20 clk, then clock low for 20 clk.
  task automatic apply_stimulus(input logic [10:0] frame, input int nbits, input bit glitch);
    for (int i = 0; i < nbits; i++) begin
      ps2_data_in = frame[i];
      if (glitch && i == 5) begin
        repeat (8) @(posedge clk);
        ps2_clk_in = 1'b0;
        repeat (2) @(posedge clk);
        ps2_clk_in = 1'b1;
        repeat (10) @(posedge clk);
      end else begin
        repeat (20) @(posedge clk);
      end
      ps2_clk_in = 1'b0;
      if (glitch && i == 6) begin
        repeat (8) @(posedge clk);
        ps2_clk_in = 1'b1;
        repeat (2) @(posedge clk);
        ps2_clk_in = 1'b0;
        repeat (10) @(posedge clk);
      end else begin
        repeat (20) @(posedge clk);
      end
      ps2_clk_in = 1'b1;
    end
    ps2_data_in = 1'b1;
  endtask

  always @(negedge clk) begin
    if (rx_valid || rx_err) begin
      if (rx_valid && rx_err) check_output("valid_err_exclusive", 32'(rx_err), 32'd0);
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("[TB] FAIL unexpected_output: valid=%0b err=%0b data=0x%0h expected no output",
                 rx_valid, rx_err, rx_data);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check_output("event_is_err", 32'(rx_err), 32'(e.is_err));
        check_output("event_is_valid", 32'(rx_valid), 32'(!e.is_err));
        check_output("rx_data", 32'(rx_data), 32'(e.data));
        check_output("reset_required", 32'(reset_required), 32'(e.rst_req));
      end
    end else if (reset_required) begin
      check_output("reset_required_alone", 32'(reset_required), 32'd0);
    end
  end

  initial begin
    rst_n        = 1'b0;
    ps2_clk_in   = 1'b1;
    ps2_data_in  = 1'b1;
    host_inhibit = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check_output("reset_rx_data", 32'(rx_data), 32'd0);
    check_output("reset_rx_valid", 32'(rx_valid), 32'd0);
    check_output("reset_rx_err", 32'(rx_err), 32'd0);
    check_output("reset_rst_req", 32'(reset_required), 32'd0);
    check_output("reset_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    repeat (10) @(posedge clk);

    push_good(8'h1C);
    apply_stimulus(make_frame(8'h1C, 1'b0), 11, 1'b0);
    repeat (60) @(posedge clk);
    check_output("idle_after_1C", 32'(busy), 32'd0);

    push_good(8'hAA);
    apply_stimulus(make_frame(8'hAA, 1'b0), 11, 1'b0);
    repeat (60) @(posedge clk);

    push_err();
    apply_stimulus(make_frame(8'h55, 1'b1), 11, 1'b0);
    repeat (60) @(posedge clk);
    check_output("data_held_after_err", 32'(rx_data), 32'hAA);

    push_good(8'h1C);
    apply_stimulus(make_frame(8'h1C, 1'b0), 11, 1'b1);
    repeat (60) @(posedge clk);

    push_good(8'hFC);
    apply_stimulus(make_frame(8'hFC, 1'b0), 11, 1'b0);
    repeat (60) @(posedge clk);

    // Partial frame aborted by inhibit: no output expected for it.
    apply_stimulus(make_frame(8'h1C, 1'b0), 5, 1'b0);
    repeat (5) @(posedge clk);
    check_output("busy_mid_frame", 32'(busy), 32'd1);
    host_inhibit = 1'b1;
    ps2_clk_in   = 1'b0;
    repeat (100) @(posedge clk);
    ps2_clk_in   = 1'b1;
    repeat (20) @(posedge clk);
    host_inhibit = 1'b0;
    repeat (5) @(posedge clk);
    check_output("idle_after_inhibit", 32'(busy), 32'd0);
    push_good(8'hAA);
    apply_stimulus(make_frame(8'hAA, 1'b0), 11, 1'b0);
    repeat (60) @(posedge clk);

`ifdef PS2_RX_TIMEOUT_EN
    begin
      int cycles;
      push_err();
      apply_stimulus(make_frame(8'h1C, 1'b0), 3, 1'b0);
      cycles = 0;
      while (busy && cycles < 400) begin
        @(posedge clk);
        cycles++;
      end
      #1;
      check_output("timeout_busy_drop", 32'(busy), 32'd0);
      check_output("timeout_latency_window", 32'(cycles >= 75 && cycles <= 100), 32'd1);
      repeat (20) @(posedge clk);
      push_good(8'h1C);
      apply_stimulus(make_frame(8'h1C, 1'b0), 11, 1'b0);
      repeat (60) @(posedge clk);
    end
`endif

    check_output("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
